// File: rtl/fetch_controller.sv
// fetch_controller: program-load and program-counter front end for the
// instruction memory stage. A host streams 16-bit instructions into
// sequential halfword slots (LOAD). After a one-cycle DRAIN the controller
// issues one fetch address per cycle (RUN) until it is halted (HALT).
// From HALT, a restart re-enters LOAD.
`timescale 1ns/1ps

module fetch_controller #(
  parameter int PROG_DEPTH = 512,
  parameter int BOOT_ADDR  = 0
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        load_valid_i,
  input  logic [15:0] load_data_i,
  input  logic        load_last_i,
  output logic        load_ready_o,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        stall_pipeline_i,
  input  logic        halt_i,
  input  logic        restart_i,
  output logic        program_mem_write_en_o,
  output logic [15:0] instruction_o,
  output logic [31:0] instruction_addr_o,
  output logic        is_valid_o,
  output logic        flush_pipeline_o,
  output logic        load_overflow_o,
  output logic [1:0]  state_o
);

  localparam int AW = $clog2(PROG_DEPTH);

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  localparam logic STALL_PIPELINE = 1'b1;
  localparam logic FLUSH_PIPELINE = 1'b1;
  localparam logic NO_FLUSH       = 1'b0;

  localparam logic [AW-1:0] BOOT_PC   = AW'(BOOT_ADDR);
  localparam logic [AW-1:0] LAST_SLOT = AW'(PROG_DEPTH - 1);

  logic [1:0]    state;
  logic [AW-1:0] load_count;
  logic [AW-1:0] pc;
  logic          overflow;
  logic [AW-1:0] out_addr;
  logic          accept;

  // Only the low AW bits of the branch target address the program store.
  logic unused_target_bits;
  assign unused_target_bits = ^branch_target_i[31:AW];

  assign accept             = (state == ST_LOAD) && load_valid_i;
  assign instruction_addr_o = {{(32-AW){1'b0}}, out_addr};
  assign load_overflow_o    = overflow;
  assign state_o            = state;

  // Combinational outputs per state; everything is forced quiet while reset is held.
  always_comb begin
    load_ready_o           = 1'b0;
    program_mem_write_en_o = 1'b0;
    instruction_o          = '0;
    out_addr               = '0;
    is_valid_o             = 1'b0;
    flush_pipeline_o       = NO_FLUSH;
    if (reset_n_i) begin
      case (state)
        ST_LOAD: begin
          load_ready_o           = 1'b1;
          program_mem_write_en_o = load_valid_i;
          instruction_o          = load_valid_i ? load_data_i : 16'h0000;
          out_addr               = load_count;
        end
        ST_DRAIN: begin
          out_addr = BOOT_PC;
        end
        ST_RUN: begin
          out_addr   = pc;
          is_valid_o = 1'b1;
          if (branch_taken_i) flush_pipeline_o = FLUSH_PIPELINE;
        end
        ST_HALT: begin
          out_addr = pc;
        end
        default: begin
          out_addr = '0;
        end
      endcase
    end
  end

  // State, load counter, program counter and sticky overflow flag.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state      <= ST_LOAD;
      load_count <= '0;
      pc         <= BOOT_PC;
      overflow   <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (accept) begin
            load_count <= load_count + 1'b1;
            if (load_last_i) begin
              state <= ST_DRAIN;
            end else if (load_count == LAST_SLOT) begin
              // Program store is full without a final marker: keep the word, flag it.
              overflow <= 1'b1;
              state    <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          pc    <= BOOT_PC;
          state <= ST_RUN;
        end
        ST_RUN: begin
          // A redirect wins over both halt and stall; halt is re-evaluated next cycle.
          if (branch_taken_i) begin
            pc <= branch_target_i[AW-1:0];
          end else if (halt_i) begin
            state <= ST_HALT;
          end else if (stall_pipeline_i != STALL_PIPELINE) begin
            pc <= pc + 1'b1;
          end
        end
        ST_HALT: begin
          if (restart_i) begin
            state      <= ST_LOAD;
            load_count <= '0;
            overflow   <= 1'b0;
          end
        end
        default: begin
          state <= ST_LOAD;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
Program-counter and program-load front end that drives the instruction memory stage. After reset it accepts a stream of 16-bit instructions from a host (valid/ready) and writes them to sequential halfword addresses. It then switches to run mode, where it generates one fetch address per cycle and handles stalls, taken branches with flush, wrap-around and halt/restart.

Parameters:
PROG_DEPTH, 512, number of 16-bit instruction slots; power of two; PC width AW = clog2(PROG_DEPTH).
BOOT_ADDR, 0, halfword index of the first fetch after a load; less than PROG_DEPTH.

Ports:
clk_i  input  1  clock
reset_n_i  input  1  reset, asynchronous assert, active-low
load_valid_i  input  1  host presents a load halfword
load_data_i  input  16  instruction to store
load_last_i  input  1  qualifies the final halfword of the program
load_ready_o  output  1  controller accepts a halfword this cycle
branch_taken_i  input  1  execute stage redirect request
branch_target_i  input  32  redirect halfword address; only bits [AW-1:0] are used
stall_pipeline_i  input  stall_pipeline_sig  STALL_PIPELINE holds the PC
halt_i  input  1  stop fetching
restart_i  input  1  leave HALT and re-enter LOAD
program_mem_write_en_o  output  1  write strobe to instruction memory
instruction_o  output  16  write data to instruction memory
instruction_addr_o  output  32  write or fetch address, zero-extended from AW bits
is_valid_o  output  1  fetch address is a real instruction
flush_pipeline_o  output  flush_pipeline_sig  FLUSH_PIPELINE on taken branch
load_overflow_o  output  1  sticky: program filled PROG_DEPTH without load_last_i
state_o  output  2  LOAD=0, DRAIN=1, RUN=2, HALT=3

Behaviour:
- Reset (reset_n_i low, asynchronous): state=LOAD, load counter=0, pc=BOOT_ADDR, load_overflow_o=0.
  - All outputs are low or no-flush while in reset.
  - A reset during a load or during run abandons it immediately; written memory contents are not cleared.
- LOAD state:
  - load_ready_o=1. A halfword is accepted when load_valid_i && load_ready_o.
  - On acceptance, combinationally: program_mem_write_en_o=1, instruction_o=load_data_i, instruction_addr_o=counter. The counter increments at the clock edge.
  - Accepting with load_last_i=1 moves to DRAIN.
  - Accepting at counter==PROG_DEPTH-1 with load_last_i=0: the word is still written, load_overflow_o is set, and the state moves to DRAIN.
  - When nothing is accepted, write_en=0 and the counter holds.
  - is_valid_o=0. branch_taken_i, stall_pipeline_i and halt_i are ignored.
- DRAIN state:
  - Lasts exactly one cycle: load_ready_o=0, write_en=0, is_valid_o=0, instruction_addr_o=BOOT_ADDR.
  - pc is loaded with BOOT_ADDR, then the state moves to RUN.
- RUN state:
  - instruction_addr_o=pc and is_valid_o=1. The instruction memory returns data and registered valid one cycle later.
  - Next pc, in priority order:
    - branch_taken_i: pc<=branch_target_i[AW-1:0]. flush_pipeline_o=FLUSH_PIPELINE in the same cycle, combinationally. Branch beats stall.
    - else if stall==STALL_PIPELINE: pc holds and is_valid_o stays 1.
    - else: pc<=pc+1 modulo PROG_DEPTH, so PROG_DEPTH-1 wraps to 0.
  - flush_pipeline_o is no-flush in every other case.
  - halt_i=1 with no branch in the same cycle: move to HALT and freeze pc. A branch in the same cycle is taken first, and the halt applies on the next cycle if halt_i is still high.
- HALT state:
  - is_valid_o=0, write_en=0, pc frozen.
  - restart_i moves to LOAD, clears the counter and clears load_overflow_o.
- load_overflow_o is cleared only by reset or restart.
- load_ready_o=0 in every state except LOAD.

Test Plan:
- Load words 0xA001, 0xA002, 0xA003 (last on the third), PROG_DEPTH=512 -> writes to addresses 0, 1, 2 with write_en for 3 cycles, one DRAIN cycle, then fetch addresses 0, 1, 2, 3 on consecutive cycles with is_valid_o=1.
- Gaps in load_valid_i during a load -> no write, counter holds, and the next write address continues contiguously.
- RUN at pc=5, stall for 2 cycles -> instruction_addr_o=5 for 3 cycles, then 6. Branch to 0x40 together with stall -> flush asserted that cycle, next address 0x40.
- pc=511 with no stall -> next address 0 (wrap). branch_target_i=0x1234 -> fetch address 0x034 (masked to 9 bits).
- Load 512 words without load_last_i -> load_overflow_o=1 after the 512th write, DRAIN, then RUN from address 0. restart_i from HALT clears the flag.
- reset_n_i asserted low asynchronously mid-load and mid-run -> outputs zero immediately. After release: state=LOAD, load_ready_o=1, counter=0.
